flash_burst_reader: RTL

Avalon-MM read master that sits directly upstream of the on-chip flash data port and drives its burst-read interface. It accepts a byte-count read request and splits it into flow-controlled sub-bursts. It packs the flash's 1-bit readdata beats LSB-first into bytes and delivers them through an internal FIFO on a valid/ready byte stream. Its consumers are the RX config loader and the firmware-copy logic.

---
 rtl/flash_burst_reader_if.sv | 31 +++
 rtl/flash_burst_reader.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/flash_burst_reader_if.sv
// flash_burst_reader_if: Avalon-MM burst-read bus to the flash data port.
// The master drives the command, the slave answers with 1-bit beats.
interface flash_burst_reader_if #(
  parameter int ADDR_W = 15,
  parameter int BC_W   = 11
);
  logic [ADDR_W-1:0] avmm_data_addr;
  logic              avmm_data_read;
  logic [BC_W-1:0]   avmm_data_burstcount;
  logic              avmm_data_waitrequest;
  logic              avmm_data_readdata;
  logic              avmm_data_readdatavalid;

  modport master (
    output avmm_data_addr,
    output avmm_data_read,
    output avmm_data_burstcount,
    input  avmm_data_waitrequest,
    input  avmm_data_readdata,
    input  avmm_data_readdatavalid
  );

  modport slave (
    input  avmm_data_addr,
    input  avmm_data_read,
    input  avmm_data_burstcount,
    output avmm_data_waitrequest,
    output avmm_data_readdata,
    output avmm_data_readdatavalid
  );
endinterface

// File: rtl/flash_burst_reader.sv
// flash_burst_reader: splits byte reads into flash sub-bursts, packs bits.
// `FLASH_RD_TIMEOUT_EN adds a TIMEOUT_CYC watchdog driving the sticky err.
module flash_burst_reader #(
  parameter int ADDR_W      = 15,
  parameter int BC_W        = 11,
  parameter int CHUNK_BYTES = 4,
  parameter int FIFO_DEPTH  = 16
`ifdef FLASH_RD_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = 1023
`endif
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [7:0]        req_nbytes,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  flash_burst_reader_if.master avmm
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(8 * CHUNK_BYTES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SPACE,
    S_ISSUE,
    S_COLLECT
  } state_t;

  state_t state, state_nx;

  logic [ADDR_W-1:0] cur_addr;
  logic [7:0]        remaining;
  logic [CW-1:0]     reserved;
  logic [BW-1:0]     beat_cnt;
  logic [2:0]        bit_idx;
  logic [6:0]        shift;
  logic              done_r, err_r, rd_r;
  logic [ADDR_W-1:0] addr_r;
  logic [BC_W-1:0]   bc_r;

  logic [7:0]        mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     fifo_cnt;

  logic [7:0]  chunk;
  logic [10:0] beats;
  logic [15:0] free;
  logic        accept, space_ok, issue_ack;
  logic        beat, last_beat, push, pop, timeout;

  assign chunk = (remaining > 8'(CHUNK_BYTES)) ?
                 8'(CHUNK_BYTES) : remaining;
  assign beats = {chunk, 3'b000};
  // Reserved slots belong to bytes of the burst still in flight.
  assign free  = 16'(FIFO_DEPTH) - 16'(fifo_cnt) - 16'(reserved);

  assign req_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign accept    = req_valid & req_ready;
  assign space_ok  = (free >= {8'd0, chunk});
  assign issue_ack = (state == S_ISSUE) & ~avmm.avmm_data_waitrequest;
  assign beat      = (state == S_COLLECT) & avmm.avmm_data_readdatavalid;
  assign last_beat = beat & (beat_cnt == BW'(1));
  assign push      = beat & (bit_idx == 3'd7);
  assign pop       = out_valid & out_ready;

  assign done = done_r;
  assign err  = err_r;

  assign avmm.avmm_data_read       = rd_r;
  assign avmm.avmm_data_addr       = addr_r;
  assign avmm.avmm_data_burstcount = bc_r;

`ifdef FLASH_RD_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYC + 1);
  logic [WW-1:0] wd_cnt;
  logic          wd_active, progress;

  assign wd_active = (state == S_ISSUE) || (state == S_COLLECT);
  assign progress  = issue_ack | beat;
  assign timeout   = wd_active & ~progress &
                     (wd_cnt == WW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clock) begin
    if (reset || !wd_active || progress || timeout)
      wd_cnt <= '0;
    else
      wd_cnt <= wd_cnt + WW'(1);
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:
        if (accept && req_nbytes != 8'd0) state_nx = S_SPACE;
      S_SPACE:
        if (space_ok) state_nx = S_ISSUE;
      S_ISSUE:
        if (issue_ack) state_nx = S_COLLECT;
      S_COLLECT:
        if (last_beat)
          state_nx = (remaining == chunk) ? S_IDLE : S_SPACE;
      default:
        state_nx = S_IDLE;
    endcase
    if (timeout) state_nx = S_IDLE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cur_addr  <= '0;
      remaining <= '0;
      reserved  <= '0;
      beat_cnt  <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
      rd_r      <= 1'b0;
      addr_r    <= '0;
      bc_r      <= '0;
    end else begin
      done_r <= 1'b0;
      if (accept) begin
        err_r <= 1'b0;
        if (req_nbytes == 8'd0) begin
          done_r <= 1'b1;
        end else begin
          cur_addr  <= req_addr;
          remaining <= req_nbytes;
        end
      end
      if (state == S_SPACE && space_ok) begin
        reserved <= reserved + CW'(chunk);
        rd_r     <= 1'b1;
        addr_r   <= cur_addr;
        bc_r     <= BC_W'(beats);
      end
      if (issue_ack) begin
        rd_r     <= 1'b0;
        cur_addr <= cur_addr + ADDR_W'(beats);
        beat_cnt <= BW'(beats);
        bit_idx  <= '0;
      end
      if (beat) begin
        // Bits enter at the top so beat 0 ends up in bit 0.
        shift    <= {avmm.avmm_data_readdata, shift[6:1]};
        bit_idx  <= bit_idx + 3'd1;
        beat_cnt <= beat_cnt - BW'(1);
        if (push) reserved <= reserved - CW'(1);
        if (last_beat) begin
          remaining <= remaining - chunk;
          if (remaining == chunk) done_r <= 1'b1;
        end
      end
      if (timeout) begin
        err_r    <= 1'b1;
        done_r   <= 1'b1;
        rd_r     <= 1'b0;
        reserved <= '0;
        bit_idx  <= '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= {avmm.avmm_data_readdata, shift};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
    end
  end

  assign out_valid = (fifo_cnt != '0);
  assign out_data  = mem[rd_ptr];

endmodule
